// File: rtl/delta_sigma_multi.sv
// ---------------------------------------------------------------------------
// delta_sigma_multi
//   Multi-channel 1-bit delta-sigma modulator (first or second order loop).
//   Each channel keeps a holding register for its sample, converts it to an
//   offset-binary value, and runs an error-feedback loop whose registered
//   sign bit is the output pulse stream.
//
// Parameters
//   WIDTH     sample width per channel (4..24)
//   CHANNELS  number of independent channels (1..8)
//   ORDER     loop order, 1 or 2
//   SIGNED_IN 1: two's-complement samples, 0: unsigned samples
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous active-high reset
//   enable       run the loops; low freezes loop state and forces pulses low
//   mute         replaces every channel input with midscale
//   sample_valid loads data_in into the holding registers
//   data_in      packed samples, channel c at [c*WIDTH +: WIDTH]
//   pulse_out    per-channel 1-bit density stream
//   sat_flag     per-channel sticky second-stage saturation indicator
// ---------------------------------------------------------------------------
module delta_sigma_multi #(
   parameter int WIDTH     = 9,
   parameter int CHANNELS  = 2,
   parameter int ORDER     = 1,
   parameter int SIGNED_IN = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         mute,
   input  logic                         sample_valid,
   input  logic [CHANNELS*WIDTH-1:0]    data_in,
   output logic [CHANNELS-1:0]          pulse_out,
   output logic [CHANNELS-1:0]          sat_flag
);

   localparam int A1W = WIDTH + 2;   // first integrator width
   localparam int A2W = WIDTH + 4;   // second integrator width
   localparam int SW  = WIDTH + 6;   // headroom for the unclamped second sum

   // Feedback of one full scale (2^WIDTH) into a1 and twice that into a2.
   localparam logic [A1W-1:0] FB1 = {2'b01, {WIDTH{1'b0}}};
   localparam logic [SW-1:0]  FB2 = {5'b00001, {(WIDTH+1){1'b0}}};

   localparam logic signed [A2W-1:0] A2_MAX = {1'b0, {(A2W-1){1'b1}}};
   localparam logic signed [A2W-1:0] A2_MIN = {1'b1, {(A2W-1){1'b0}}};

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0]      h;
      logic [WIDTH-1:0]      u;
      logic signed [A1W-1:0] a1;
      logic signed [A1W-1:0] a1_next;
      logic                  fire;

      // Holding register; a sample loaded at edge k reaches the loop at k+1
      // because the loop always consumes the value already held.
      always_ff @(posedge clk) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (reset)
            h <= '0;
         else if (sample_valid)
            h <= data_in[c*WIDTH +: WIDTH];
      end

      // Offset-binary input: signed samples flip the MSB to map to unsigned.
      always_comb begin
         // NOTE: every combinational output gets a default first so no
         // path leaves it unassigned and a latch cannot be inferred.
         u = h;
         if (mute)
            u = {1'b1, {(WIDTH-1){1'b0}}};
         else if (SIGNED_IN != 0)
            u = {~h[WIDTH-1], h[WIDTH-2:0]};
      end

      assign a1_next = a1 + $signed({2'b00, u}) - $signed(fire ? FB1 : '0);

      always_ff @(posedge clk) begin
         if (reset)
            a1 <= '1;
         else if (enable)
            a1 <= a1_next;
      end

      if (ORDER == 2) begin : g_o2
         logic signed [A2W-1:0] a2;
         logic signed [A2W-1:0] a2_next;
         logic [SW-1:0]         s2;
         logic                  ovf;
         logic                  sat_q;

         // Full-precision sum; it overflows a2 exactly when the bits above
         // the a2 sign position disagree with it.
         always_comb begin
            s2 = {{2{a2[A2W-1]}}, a2} + {{4{a1[A1W-1]}}, a1}
               + {6'b000000, u} - (fire ? FB2 : '0);
            ovf     = (s2[SW-1:A2W-1] != '0) && (s2[SW-1:A2W-1] != '1);
            a2_next = s2[A2W-1:0];
            if (ovf)
               a2_next = s2[SW-1] ? A2_MIN : A2_MAX;
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               a2    <= '1;
               sat_q <= 1'b0;
            end else if (enable) begin
               a2 <= a2_next;
               if (ovf)
                  sat_q <= 1'b1;
            end
         end

         assign fire        = ~a2[A2W-1];
         assign sat_flag[c] = sat_q;
      end else begin : g_o1
         assign fire        = ~a1[A1W-1];
         assign sat_flag[c] = 1'b0;
      end

      // Output is the registered sign, gated only by the run control.
      assign pulse_out[c] = enable & fire;
   end

endmodule

// File: tb/tb_delta_sigma_multi.sv
// ---------------------------------------------------------------------------
// tb_delta_sigma_multi
//   Directed bench for delta_sigma_multi. Three instances share the clock and
//   reset: a 2-channel unsigned first-order loop, a 1-channel signed
//   first-order loop, and a 1-channel 8-bit second-order loop compared
//   against a behavioural reference.
// ---------------------------------------------------------------------------
module tb_delta_sigma_multi;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 2-channel, WIDTH=4, ORDER=1, unsigned
   logic       en_u = 1'b0, mute_u = 1'b0, sv_u = 1'b0;
   logic [7:0] data_u = '0;
   logic [1:0] pulse_u, sat_u;

   // 1-channel, WIDTH=4, ORDER=1, signed
   logic       en_s = 1'b0, mute_s = 1'b0, sv_s = 1'b0;
   logic [3:0] data_s = '0;
   logic [0:0] pulse_s, sat_s;

   // 1-channel, WIDTH=8, ORDER=2, unsigned
   logic       en_2 = 1'b0, mute_2 = 1'b0, sv_2 = 1'b0;
   logic [7:0] data_2 = '0;
   logic [0:0] pulse_2, sat_2;

   delta_sigma_multi #(.WIDTH(4), .CHANNELS(2), .ORDER(1), .SIGNED_IN(0)) dut_u (
      .clk(clk), .reset(reset), .enable(en_u), .mute(mute_u),
      .sample_valid(sv_u), .data_in(data_u), .pulse_out(pulse_u), .sat_flag(sat_u));

   delta_sigma_multi #(.WIDTH(4), .CHANNELS(1), .ORDER(1), .SIGNED_IN(1)) dut_s (
      .clk(clk), .reset(reset), .enable(en_s), .mute(mute_s),
      .sample_valid(sv_s), .data_in(data_s), .pulse_out(pulse_s), .sat_flag(sat_s));

   delta_sigma_multi #(.WIDTH(8), .CHANNELS(1), .ORDER(2), .SIGNED_IN(0)) dut_2 (
      .clk(clk), .reset(reset), .enable(en_2), .mute(mute_2),
      .sample_valid(sv_2), .data_in(data_2), .pulse_out(pulse_2), .sat_flag(sat_2));

   // Advance one edge and settle; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Hand-derived patterns after loading ch0 u=8, ch1 u=4 (index n counts
   // edges after the load edge): u=8 gives a1 7,-1,7,... ; u=4 gives
   // a1 3,-9,-5,-1,3,...
   function automatic logic [1:0] exp_pattern(input int n);
      logic e0, e1;
      e0 = (n % 2) == 1;
      e1 = (n % 4) == 1;
      return {e1, e0};
   endfunction

   task automatic load_pattern();
      data_u = {4'd4, 4'd8};
      sv_u   = 1'b1;
      tick();
      sv_u   = 1'b0;
      checks++;
      if (pulse_u !== 2'b00) begin
         failures++;
         $display("FAIL load_edge: pulse_out=%b expected=%b", pulse_u, 2'b00);
      end
   endtask

   task automatic run_pattern(input string tag, input int n_first, input int n_last);
      for (int n = n_first; n <= n_last; n++) begin
         tick();
         checks++;
         if (pulse_u !== exp_pattern(n)) begin
            failures++;
            $display("FAIL %s n=%0d: pulse_out=%b expected=%b", tag, n, pulse_u, exp_pattern(n));
         end
      end
   endtask

   task automatic test_reset();
      en_u = 1'b1; en_s = 1'b1; en_2 = 1'b1;
      // Reset must win over a concurrent sample load.
      sv_u = 1'b1; data_u = 8'hFF;
      do_reset();
      sv_u = 1'b0;
      checks++;
      if (pulse_u !== 2'b00 || sat_u !== 2'b00) begin
         failures++;
         $display("FAIL reset_u: pulse=%b sat=%b expected pulse=00 sat=00", pulse_u, sat_u);
      end
      checks++;
      if (pulse_s !== 1'b0) begin
         failures++;
         $display("FAIL reset_s: pulse=%b expected=0", pulse_s);
      end
      checks++;
      if (pulse_2 !== 1'b0 || sat_2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_2: pulse=%b sat=%b expected pulse=0 sat=0", pulse_2, sat_2);
      end
      // h was cleared, so u=0 keeps a1 at -1 and the output silent.
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (pulse_u !== 2'b00) begin
            failures++;
            $display("FAIL zero_input cyc=%0d: pulse=%b expected=00", i, pulse_u);
         end
      end
   endtask

   task automatic test_patterns();
      do_reset();
      load_pattern();
      run_pattern("pattern", 1, 6);
      // Freeze for five edges: outputs low, state held.
      en_u = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (pulse_u !== 2'b00) begin
            failures++;
            $display("FAIL freeze cyc=%0d: pulse=%b expected=00", i, pulse_u);
         end
      end
      en_u = 1'b1;
      run_pattern("resume", 7, 14);
   endtask

   task automatic test_midstream_reset();
      run_pattern("pre_reset", 15, 17);
      sv_u = 1'b1; data_u = 8'h5A;
      do_reset();
      sv_u = 1'b0;
      checks++;
      if (pulse_u !== 2'b00 || sat_u !== 2'b00) begin
         failures++;
         $display("FAIL mid_reset: pulse=%b sat=%b expected pulse=00 sat=00", pulse_u, sat_u);
      end
      load_pattern();
      run_pattern("post_reset", 1, 8);
   endtask

   task automatic test_signed();
      int ones;
      do_reset();
      // Data 0 is midscale once the MSB is flipped: 1,0,1,0 ...
      for (int n = 1; n <= 4; n++) begin
         tick();
         checks++;
         if (pulse_s !== 1'((n % 2) == 1)) begin
            failures++;
            $display("FAIL signed_zero n=%0d: pulse=%b expected=%b", n, pulse_s, (n % 2) == 1);
         end
      end
      // Muting midscale data must not change the alternation.
      mute_s = 1'b1;
      for (int n = 5; n <= 8; n++) begin
         tick();
         checks++;
         if (pulse_s !== 1'((n % 2) == 1)) begin
            failures++;
            $display("FAIL signed_mute n=%0d: pulse=%b expected=%b", n, pulse_s, (n % 2) == 1);
         end
      end
      // Load +7 (u=15) while muted; mute still dominates.
      data_s = 4'b0111;
      sv_s   = 1'b1;
      for (int n = 9; n <= 10; n++) begin
         tick();
         sv_s = 1'b0;
         checks++;
         if (pulse_s !== 1'((n % 2) == 1)) begin
            failures++;
            $display("FAIL signed_mute_load n=%0d: pulse=%b expected=%b", n, pulse_s, (n % 2) == 1);
         end
      end
      // Unmuted u=15: a1 walks 14..0,-1 -> 15 ones in every 16 cycles.
      mute_s = 1'b0;
      for (int w = 0; w < 2; w++) begin
         ones = 0;
         for (int i = 0; i < 16; i++) begin
            tick();
            ones += int'(pulse_s);
         end
         checks++;
         if (ones !== 15) begin
            failures++;
            $display("FAIL signed_max window=%0d: ones=%0d expected=15", w, ones);
         end
      end
      // Mute again: after at most two settling edges the loop alternates.
      mute_s = 1'b1;
      tick();
      tick();
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         ones += int'(pulse_s);
      end
      checks++;
      if (ones !== 8) begin
         failures++;
         $display("FAIL signed_remute: ones=%0d expected=8", ones);
      end
      mute_s = 1'b0;
   endtask

   // Reference for the second-order 8-bit channel.
   int m_a1, m_a2, m_h;
   logic m_sat;

   task automatic model_step(input logic sv, input int data);
      int u, fb, n1, n2;
      u  = m_h;
      fb = (m_a2 >= 0) ? 256 : 0;
      n1 = m_a1 + u - fb;
      n1 = n1 & 32'h3FF;
      if (n1 >= 512) n1 = n1 - 1024;
      n2 = m_a2 + m_a1 + u - 2 * fb;
      if (n2 > 2047) begin
         n2 = 2047;
         m_sat = 1'b1;
      end else if (n2 < -2048) begin
         n2 = -2048;
         m_sat = 1'b1;
      end
      m_a1 = n1;
      m_a2 = n2;
      if (sv) m_h = data;
   endtask

   task automatic run_order2(input string tag, input int cycles, input bit ramp);
      int mism;
      int first;
      mism  = 0;
      first = -1;
      for (int i = 0; i < cycles; i++) begin
         if (ramp) begin
            data_2 = 8'(i / 16);
            sv_2   = 1'b1;
         end
         tick();
         model_step(sv_2, int'(data_2));
         if (pulse_2 !== 1'(m_a2 >= 0) || sat_2 !== m_sat) begin
            mism++;
            if (first < 0) first = i;
         end
         sv_2 = 1'b0;
      end
      checks++;
      if (mism !== 0) begin
         failures++;
         $display("FAIL %s: mismatching_cycles=%0d first_at=%0d expected 0 mismatches", tag, mism, first);
      end
      checks++;
      if (sat_2 !== m_sat) begin
         failures++;
         $display("FAIL %s_sat: sat_flag=%b expected=%b", tag, sat_2, m_sat);
      end
   endtask

   task automatic test_order2();
      do_reset();
      m_a1 = -1; m_a2 = -1; m_h = 0; m_sat = 1'b0;
      checks++;
      if (pulse_2 !== 1'b0 || sat_2 !== 1'b0) begin
         failures++;
         $display("FAIL o2_reset: pulse=%b sat=%b expected pulse=0 sat=0", pulse_2, sat_2);
      end
      run_order2("o2_ramp", 4096, 1'b1);
      data_2 = 8'd255;
      sv_2   = 1'b1;
      tick();
      model_step(1'b1, 255);
      sv_2 = 1'b0;
      run_order2("o2_fullscale", 3000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_midstream_reset();
      test_signed();
      test_order2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
